// File: rtl/bus_operand_loader.sv
// Captures ALU operands A/B from the shared bus under read strobes and issues a
// one-cycle op_sel once both are valid; done follows one cycle later.
module bus_operand_loader #(
  parameter int WIDTH    = 4,
  parameter int OP_W     = 2,
  parameter int KEEP_OPS = 0
) (
  input  logic             i_clk,
  input  logic             i_grst,
  input  logic             i_lrst,
  input  logic [WIDTH-1:0] i_bus,
  input  logic             i_rs1,
  input  logic             i_rs2,
  input  logic [OP_W-1:0]  i_op_req,
  input  logic             i_op_valid,
  output logic [WIDTH-1:0] o_a_out,
  output logic [WIDTH-1:0] o_b_out,
  output logic [OP_W-1:0]  o_op_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic KEEP = (KEEP_OPS != 0);

  state_t r_state;
  logic   r_a_vld;
  logic   r_b_vld;

  logic w_rst;
  logic w_req;
  logic w_both_vld;
  logic w_done_vld;

  assign w_rst      = i_grst | i_lrst;
  assign w_req      = i_op_valid & (|i_op_req);
  assign w_both_vld = r_a_vld & r_b_vld;
  // Operand validity as it will stand once DONE retires (cleared unless chaining).
  assign w_done_vld = KEEP & w_both_vld;

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_state  <= S_IDLE;
      r_a_vld  <= 1'b0;
      r_b_vld  <= 1'b0;
      o_a_out  <= '0;
      o_b_out  <= '0;
      o_op_sel <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_err  <= 1'b0;
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req && w_both_vld) begin
            r_state  <= S_EXEC;
            o_op_sel <= i_op_req;
            o_busy   <= 1'b1;
          end else begin
            if (w_req) o_err <= 1'b1;
            if (i_rs1) begin
              o_a_out <= i_bus;
              r_a_vld <= 1'b1;
            end
            if (i_rs2) begin
              o_b_out <= i_bus;
              r_b_vld <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_state  <= S_DONE;
          o_op_sel <= '0;
          o_done   <= 1'b1;
        end
        S_DONE: begin
          // Strobes are ignored here, but a request presented on the edge that
          // retires DONE is judged against the post-DONE operand validity.
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          if (!KEEP) begin
            r_a_vld <= 1'b0;
            r_b_vld <= 1'b0;
          end
          if (w_req) begin
            if (w_done_vld) begin
              r_state  <= S_EXEC;
              o_op_sel <= i_op_req;
              o_busy   <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          o_op_sel <= '0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
